// File: rtl/exec_sequencer.sv
// exec_sequencer
// Multi-cycle execute sequencer for the Simple RISC Machine. It takes one
// register-to-register operation per start/ready handshake, reads Rn and Rm
// from the register file, runs Rm through a one-bit shifter, and runs the
// operands through the ALU. It then writes the result back to Rd and updates
// the Z/N/V status flags. Every operation takes the same five-state path:
// IDLE -> RD_A -> RD_B -> EXEC -> WB.
//
// Ports:
//   clk, reset_n           clock, synchronous active-low reset
//   start / ready          request handshake (accepted on start & ready)
//   op, shift, rn, rm, rd  operation, Rm shift, register numbers
//   imm                    MOVI immediate (sign-extended)
//   readnum / rf_data_out  register file read select / combinational data
//   writenum, write,       register file write select, enable, data
//   data_in
//   done                   one-cycle pulse in the WB state
//   Z, N, V                registered zero / negative / overflow flags
module exec_sequencer #(
  parameter int data_width = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  output logic                  ready,
  input  logic [2:0]            op,
  input  logic [1:0]            shift,
  input  logic [2:0]            rn,
  input  logic [2:0]            rm,
  input  logic [2:0]            rd,
  input  logic [7:0]            imm,
  output logic [2:0]            readnum,
  input  logic [data_width-1:0] rf_data_out,
  output logic [2:0]            writenum,
  output logic                  write,
  output logic [data_width-1:0] data_in,
  output logic                  done,
  output logic                  Z,
  output logic                  N,
  output logic                  V
);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_CMP  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_MVN  = 3'b011;
  localparam logic [2:0] OP_MOVI = 3'b100;
  localparam logic [2:0] OP_MOV  = 3'b101;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_A = 3'd1,
    RD_B = 3'd2,
    EXEC = 3'd3,
    WB   = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic                  ready_q, ready_d;
  logic [2:0]            op_q, op_d;
  logic [1:0]            shift_q, shift_d;
  logic [2:0]            rm_q, rm_d;
  logic [2:0]            rd_q, rd_d;
  logic [7:0]            imm_q, imm_d;
  logic [data_width-1:0] a_q, a_d;
  logic [data_width-1:0] b_q, b_d;
  logic [data_width-1:0] c_q, c_d;
  logic                  z_q, z_d;
  logic                  n_q, n_d;
  logic                  v_q, v_d;
  logic [2:0]            readnum_q, readnum_d;
  logic [2:0]            writenum_q, writenum_d;
  logic                  write_q, write_d;
  logic [data_width-1:0] data_in_q, data_in_d;
  logic                  done_q, done_d;

  // Shifted B operand and the candidate ALU results, all modulo 2^data_width.
  logic [data_width-1:0] bs;
  logic [data_width-1:0] sum;
  logic [data_width-1:0] diff;
  logic [data_width-1:0] imm_ext;

  always_comb begin
    bs = b_q;
    case (shift_q)
      2'b01:   bs = {b_q[data_width-2:0], 1'b0};
      2'b10:   bs = {1'b0, b_q[data_width-1:1]};
      2'b11:   bs = {b_q[data_width-1], b_q[data_width-1:1]};
      default: bs = b_q;
    endcase
    sum     = a_q + bs;
    diff    = a_q - bs;
    imm_ext = {{(data_width-8){imm_q[7]}}, imm_q};
  end

  // Next-state logic. The read select is loaded with Rn at the accept edge, so
  // it is already valid throughout RD_A, and with Rm at the end of RD_A. The
  // WB outputs (write, done, writenum, data_in) are computed during EXEC, so
  // they are registered and valid for exactly the WB cycle.
  always_comb begin
    state_d    = state_q;
    ready_d    = ready_q;
    op_d       = op_q;
    shift_d    = shift_q;
    rm_d       = rm_q;
    rd_d       = rd_q;
    imm_d      = imm_q;
    a_d        = a_q;
    b_d        = b_q;
    c_d        = c_q;
    z_d        = z_q;
    n_d        = n_q;
    v_d        = v_q;
    readnum_d  = readnum_q;
    writenum_d = writenum_q;
    write_d    = 1'b0;
    data_in_d  = data_in_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          op_d      = op;
          shift_d   = shift;
          rm_d      = rm;
          rd_d      = rd;
          imm_d     = imm;
          readnum_d = rn;
          ready_d   = 1'b0;
          state_d   = RD_A;
        end
      end
      RD_A: begin
        a_d       = rf_data_out;
        readnum_d = rm_q;
        state_d   = RD_B;
      end
      RD_B: begin
        b_d     = rf_data_out;
        state_d = EXEC;
      end
      EXEC: begin
        // Reserved codes keep C and the flags as they were.
        case (op_q)
          OP_ADD: begin
            c_d = sum;
            v_d = (a_q[data_width-1] == bs[data_width-1]) &&
                  (sum[data_width-1] != a_q[data_width-1]);
          end
          OP_CMP: begin
            c_d = diff;
            v_d = (a_q[data_width-1] != bs[data_width-1]) &&
                  (diff[data_width-1] != a_q[data_width-1]);
          end
          OP_AND: begin
            c_d = a_q & bs;
            v_d = 1'b0;
          end
          OP_MVN: begin
            c_d = ~bs;
            v_d = 1'b0;
          end
          OP_MOVI: begin
            c_d = imm_ext;
            v_d = 1'b0;
          end
          OP_MOV: begin
            c_d = bs;
            v_d = 1'b0;
          end
          default: begin
            c_d = c_q;
            v_d = v_q;
          end
        endcase
        if (op_q != 3'b110 && op_q != 3'b111) begin
          z_d = (c_d == '0);
          n_d = c_d[data_width-1];
        end
        writenum_d = rd_q;
        data_in_d  = c_d;
        write_d    = (op_q == OP_ADD) || (op_q == OP_AND) || (op_q == OP_MVN) ||
                     (op_q == OP_MOVI) || (op_q == OP_MOV);
        done_d     = 1'b1;
        state_d    = WB;
      end
      WB: begin
        ready_d = 1'b1;
        state_d = IDLE;
      end
      default: begin
        ready_d = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  // All state and registered outputs. A reset at any point drops back to IDLE
  // with write cleared, so an operation aborted mid-flight never commits.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      ready_q    <= 1'b1;
      op_q       <= '0;
      shift_q    <= '0;
      rm_q       <= '0;
      rd_q       <= '0;
      imm_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      z_q        <= 1'b0;
      n_q        <= 1'b0;
      v_q        <= 1'b0;
      readnum_q  <= '0;
      writenum_q <= '0;
      write_q    <= 1'b0;
      data_in_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      op_q       <= op_d;
      shift_q    <= shift_d;
      rm_q       <= rm_d;
      rd_q       <= rd_d;
      imm_q      <= imm_d;
      a_q        <= a_d;
      b_q        <= b_d;
      c_q        <= c_d;
      z_q        <= z_d;
      n_q        <= n_d;
      v_q        <= v_d;
      readnum_q  <= readnum_d;
      writenum_q <= writenum_d;
      write_q    <= write_d;
      data_in_q  <= data_in_d;
      done_q     <= done_d;
    end
  end

  assign ready    = ready_q;
  assign readnum  = readnum_q;
  assign writenum = writenum_q;
  assign write    = write_q;
  assign data_in  = data_in_q;
  assign done     = done_q;
  assign Z        = z_q;
  assign N        = n_q;
  assign V        = v_q;

endmodule

// File: doc/exec_sequencer.md
# exec_sequencer

Multi-cycle execute sequencer for the Simple RISC Machine. It sits between instruction issue and the 8 x `data_width` register file. It accepts one register-to-register operation per handshake, drives the register file read port to fetch two operands, and runs them through a shifter and ALU. It then writes the result back through the register file write port and updates the status flags.

## Interface
Parameters:
- `data_width`, 16, width of registers, operands and result.

Ports:
- `clk`  in  1  rising-edge clock; single clock domain.
- `reset_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  request valid; accepted when `start & ready` at a rising edge.
- `ready`  out  1  high only in IDLE.
- `op`  in  3  operation code: 000 ADD, 001 CMP, 010 AND, 011 MVN, 100 MOVI, 101 MOV; 110 and 111 are reserved.
- `shift`  in  2  shift applied to the Rm operand: 00 none, 01 LSL1, 10 LSR1 (zero fill), 11 ASR1.
- `rn`, `rm`, `rd`  in  3 each  source A, source B and destination register numbers.
- `imm`  in  8  MOVI immediate; sign-extended to `data_width`.
- `readnum`  out  3  register file read select.
- `rf_data_out`  in  `data_width`  register file combinational read data.
- `writenum`  out  3  register file write select.
- `write`  out  1  register file write enable.
- `data_in`  out  `data_width`  register file write data.
- `done`  out  1  one-cycle pulse in the WB state.
- `Z`, `N`, `V`  out  1 each  registered status flags: zero, negative, signed overflow.

## Operation
- On accept, latch `op`, `shift`, `rn`, `rm`, `rd` and `imm`. Input changes after accept have no effect.
- FSM states: IDLE -> RD_A -> RD_B -> EXEC -> WB -> IDLE. Transitions are unconditional except IDLE, which leaves only on accept.
- Every op, including MOVI and reserved codes, traverses all states. This keeps latency fixed.
- RD_A: `readnum` = Rn; capture `rf_data_out` into A at the end of the cycle.
- RD_B: `readnum` = Rm; capture `rf_data_out` into B at the end of the cycle.
- EXEC: Bs = shift(B). Compute the result and capture it into C; update the flags.
  - ADD: C = A + Bs.
  - CMP: C = A − Bs; flags only.
  - AND: C = A & Bs.
  - MVN: C = ~Bs.
  - MOVI: C = sext(imm).
  - MOV: C = Bs.
  - Reserved codes: C unchanged, flags unchanged.
- Arithmetic is modulo 2^`data_width`; carry is discarded.
- Flags are updated in EXEC for every non-reserved op:
  - Z = (result == 0).
  - N = result MSB.
  - ADD: V = (A[msb] == Bs[msb]) & (res[msb] != A[msb]).
  - CMP: V = (A[msb] != Bs[msb]) & (res[msb] != A[msb]).
  - AND, MVN, MOVI, MOV: V = 0.
- WB:
  - `writenum` = Rd and `data_in` = C in all cases.
  - `write` = 1 for ADD, AND, MVN, MOVI and MOV; `write` = 0 for CMP and reserved codes.
  - `done` = 1.
- `start` while not ready is ignored and not queued.
- Outside RD_A and RD_B, `readnum` holds its last value. Outside WB, `write` = 0.

## Timing
- Reset (`reset_n` = 0 at an edge) sets:
  - state to IDLE, `ready` = 1;
  - `write` = 0, `done` = 0;
  - `readnum` = 0, `writenum` = 0, `data_in` = 0;
  - A, B, C = 0 and Z, N, V = 0.
- Reset mid-operation aborts with no register file write. `ready` is 1 in the first cycle after release.
- Accept at edge k:
  - RD_A occupies cycle k+1.
  - RD_B occupies cycle k+2.
  - EXEC occupies cycle k+3; flags are visible from cycle k+4.
  - WB occupies cycle k+4; the register file commits at the edge ending k+4.
  - `ready` returns in cycle k+5.
- Throughput is 1 op per 5 cycles. The earliest next accept is at the edge ending k+5, so back-to-back ops always read the previously written value and need no forwarding.
- Rd equal to Rn or Rm is legal. The operands were captured before WB.

## Test plan
- Reset check: hold `reset_n` = 0 for 2 cycles with `start` = 1.
  - Required: `ready` = 1; `write`, `done`, Z, N, V = 0; `readnum`, `writenum`, `data_in` = 0; no accept.
- MOVI r0, 0x05 then MOVI r1, 0xFE.
  - Required: `write` high exactly in cycle k+4 with `writenum` = 0 and `data_in` = 0x0005, then 1 and 0xFFFE.
  - Required: `done` pulses once per op.
- ADD r2 = r0 + (r1 LSL1).
  - Required: `readnum` = 0 then 1; `data_in` = 0x0001; Z = 0, N = 0, V = 0.
- CMP r0, r0.
  - Required: Z = 1, N = 0, V = 0; `write` stays 0 throughout; `done` pulses.
- MOVI r6, 0xFF; MOV r5 = r6 LSR1; ADD r7 = r5 + r5.
  - Required: r5 = 0x7FFF and r7 = 0xFFFE, with N = 1, V = 1, Z = 0.
- Robustness: pulse `start` during RD_B and assert `reset_n` = 0 during EXEC of an ADD.
  - Required: the extra `start` is ignored; no `write` occurs; `ready` = 1 after release; the target register is unchanged.
